// File: rtl/bft_leaf_interface_pkg.sv
// BFT leaf endpoint shared types and helpers.
// Packet layout is {valid, dest, payload}, MSB first.
package bft_leaf_interface_pkg;

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_BOUNCE,
    SEL_TX
  } out_sel_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/bft_leaf_interface_sync_fifo.sv
// Synchronous FIFO with show-ahead head.
// Pointers carry an extra wrap bit to tell full from empty.
module bft_leaf_interface_sync_fifo #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [width-1:0] data_i,
  output logic [width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int IW = $clog2(depth);
  localparam int PW = IW + 1;

  logic [width-1:0] mem_q [depth];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[IW-1:0] == rptr_q[IW-1:0])
                && (wptr_q[IW] != rptr_q[IW]);
  assign data_o  = mem_q[rptr_q[IW-1:0]];
  assign wptr_d  = wptr_q + PW'(push_i);
  assign rptr_d  = rptr_q + PW'(pop_i);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Full-with-pop writes over the slot being read out this cycle.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[IW-1:0]] <= data_i;
  end

endmodule

// File: rtl/bft_leaf_interface.sv
// Leaf endpoint of the BFT deflection network: packetizes a local
// stream, reinjects turnback bounces, delivers self-addressed packets.
module bft_leaf_interface
  import bft_leaf_interface_pkg::*;
#(
  parameter int num_leaves = 256,
  parameter int payload_sz = 43,
  localparam int AW = $clog2(num_leaves),
  parameter logic [AW-1:0] addr = '0,
  parameter int p_sz = 52,
  parameter int tx_depth = 16,
  parameter int rx_depth = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [payload_sz-1:0] din,
  input  logic [AW-1:0]         din_dest,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [p_sz-1:0]       bus_o,
  input  logic [p_sz-1:0]       bus_i,
  output logic [payload_sz-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  rx_overflow,
  output logic [CNT_W-1:0]      rx_drop_cnt
);

  localparam int VLD = p_sz - 1;
  localparam int DHI = p_sz - 2;
  localparam int DLO = payload_sz;

  logic            tx_full, tx_empty;
  logic            tx_push, tx_pop;
  logic [p_sz-1:0] tx_head;
  logic            rx_full, rx_empty;
  logic            rx_push, rx_pop;
  logic            bounce, deliver, drop;
  out_sel_e        sel;

  logic             up_q;
  logic             ovf_q;
  logic [p_sz-1:0]  bus_q, bus_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bounce  = bus_i[VLD] && (bus_i[DHI:DLO] != addr);
  assign deliver = bus_i[VLD] && (bus_i[DHI:DLO] == addr);

  // up_q keeps din_ready low for as long as reset is held.
  assign din_ready  = up_q && !tx_full;
  assign tx_push    = din_valid && din_ready;
  assign tx_pop     = (sel == SEL_TX);
  assign dout_valid = !rx_empty;
  assign rx_pop     = dout_ready && dout_valid;
  assign rx_push    = deliver && (!rx_full || rx_pop);
  assign drop       = deliver && !rx_push;

  always_comb begin
    sel   = SEL_NONE;
    bus_d = '0;
    unique case (1'b1)
      bounce: begin
        sel   = SEL_BOUNCE;
        bus_d = bus_i;
      end
      (!bounce && !tx_empty): begin
        sel   = SEL_TX;
        bus_d = tx_head;
      end
      default: ;
    endcase
  end

  assign cnt_d = drop ? sat_inc(cnt_q) : cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      up_q  <= 1'b0;
      bus_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      up_q  <= 1'b1;
      bus_q <= bus_d;
      ovf_q <= ovf_q | drop;
      cnt_q <= cnt_d;
    end
  end

  assign bus_o       = bus_q;
  assign rx_overflow = ovf_q;
  assign rx_drop_cnt = cnt_q;

  bft_leaf_interface_sync_fifo #(
    .width (p_sz),
    .depth (tx_depth)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .data_i  ({1'b1, din_dest, din}),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  bft_leaf_interface_sync_fifo #(
    .width (payload_sz),
    .depth (rx_depth)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .data_i  (bus_i[DLO-1:0]),
    .data_o  (dout),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

endmodule

// File: tb/tb_bft_leaf_interface.sv
// Self-checking bench for bft_leaf_interface (addr=5, 256 leaves).
// Directed scenarios plus random traffic against a queue-level model.
module tb_bft_leaf_interface;

  localparam int AW  = 8;
  localparam int PL  = 43;
  localparam int PS  = 52;
  localparam int DEP = 16;
  localparam logic [AW-1:0] ME = 8'd5;

  logic          clk = 1'b0;
  logic          reset;
  logic [PL-1:0] din;
  logic [AW-1:0] din_dest;
  logic          din_valid;
  logic          din_ready;
  logic [PS-1:0] bus_o;
  logic [PS-1:0] bus_i;
  logic [PL-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          rx_overflow;
  logic [15:0]   rx_drop_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [PS-1:0] txq[$];
  logic [PL-1:0] rxq[$];
  logic [PS-1:0] m_bus = '0;
  logic          m_ovf = 1'b0;
  logic [15:0]   m_cnt = '0;
  logic          m_up = 1'b0;

  always #5 clk = ~clk;

  bft_leaf_interface #(
    .num_leaves (256),
    .payload_sz (PL),
    .addr       (ME),
    .p_sz       (PS),
    .tx_depth   (DEP),
    .rx_depth   (DEP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_dest    (din_dest),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .bus_o       (bus_o),
    .bus_i       (bus_i),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .rx_overflow (rx_overflow),
    .rx_drop_cnt (rx_drop_cnt)
  );

  function automatic logic [PS-1:0] pkt(
    input logic [AW-1:0] d,
    input logic [PL-1:0] p
  );
    return {1'b1, d, p};
  endfunction

  function automatic logic [PL-1:0] rnd_pl();
    return PL'({$urandom(), $urandom()});
  endfunction

  task automatic idle();
    din       = '0;
    din_dest  = '0;
    din_valid = 1'b0;
    bus_i     = '0;
    dout_ready = 1'b0;
  endtask

  // Advance the model by one clock from the current inputs, then the DUT.
  task automatic tick();
    bit acc, rpop;
    if (!reset) begin
      txq.delete();
      rxq.delete();
      m_bus = '0;
      m_ovf = 1'b0;
      m_cnt = '0;
      m_up  = 1'b0;
    end else begin
      acc  = din_valid && m_up && (txq.size() < DEP);
      rpop = dout_ready && (rxq.size() > 0);
      if (bus_i[PS-1] && bus_i[PS-2:PL] != ME)
        m_bus = bus_i;
      else if (txq.size() > 0)
        m_bus = txq.pop_front();
      else
        m_bus = '0;
      if (acc) txq.push_back({1'b1, din_dest, din});
      if (rpop) rxq.delete(0);
      if (bus_i[PS-1] && bus_i[PS-2:PL] == ME) begin
        if (rxq.size() < DEP) begin
          rxq.push_back(bus_i[PL-1:0]);
        end else begin
          m_ovf = 1'b1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end
      m_up = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (bus_o !== '0) begin
      failures++;
      $display("FAIL rst_bus_o got=%h exp=0", bus_o);
    end
    checks++;
    if (din_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_din_ready got=%b exp=0", din_ready);
    end
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_dout_valid got=%b exp=0", dout_valid);
    end
    checks++;
    if (rx_overflow !== 1'b0 || rx_drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_drop got=%b/%0d exp=0/0",
               rx_overflow, rx_drop_cnt);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (din_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_release_ready got=%b exp=1", din_ready);
    end
  endtask

  task automatic test_idle_injection();
    logic [PS-1:0] e;
    e = {1'b1, 8'd9, 43'h123};
    idle();
    din_valid = 1'b1;
    din_dest  = 8'd9;
    din       = 43'h123;
    checks++;
    if (din_ready !== 1'b1) begin
      failures++;
      $display("FAIL inj_ready got=%b exp=1", din_ready);
    end
    tick();
    idle();
    checks++;
    if (bus_o !== '0) begin
      failures++;
      $display("FAIL inj_t1 got=%h exp=0", bus_o);
    end
    tick();
    checks++;
    if (bus_o !== e) begin
      failures++;
      $display("FAIL inj_t2 got=%h exp=%h", bus_o, e);
    end
    tick();
    checks++;
    if (bus_o !== '0) begin
      failures++;
      $display("FAIL inj_t3 got=%h exp=0", bus_o);
    end
  endtask

  task automatic test_deliver();
    idle();
    bus_i = pkt(ME, 43'h7AA);
    tick();
    bus_i = '0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 43'h7AA) begin
      failures++;
      $display("FAIL dlv_t1 got=%b/%h exp=1/7aa", dout_valid, dout);
    end
    checks++;
    if (bus_o !== '0) begin
      failures++;
      $display("FAIL dlv_no_fwd got=%h exp=0", bus_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dout_valid !== 1'b1 || dout !== 43'h7AA) begin
        failures++;
        $display("FAIL dlv_hold%0d got=%b/%h exp=1/7aa",
                 i, dout_valid, dout);
      end
    end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL dlv_pop got=%b exp=0", dout_valid);
    end
  endtask

  task automatic test_bounce_priority();
    logic [PS-1:0] exp_q[8];
    logic [PL-1:0] pay[3];
    logic [AW-1:0] dst[3];
    for (int i = 0; i < 3; i++) begin
      pay[i] = rnd_pl();
      dst[i] = AW'($urandom_range(0, 255));
    end
    for (int i = 0; i < 4; i++)
      exp_q[i] = pkt(8'd12, PL'(32'h56 + i));
    for (int i = 0; i < 3; i++)
      exp_q[4+i] = pkt(dst[i], pay[i]);
    exp_q[7] = '0;
    idle();
    for (int c = 0; c < 10; c++) begin
      din_valid = (c < 3);
      din_dest  = (c < 3) ? dst[c] : '0;
      din       = (c < 3) ? pay[c] : '0;
      bus_i = (c >= 1 && c <= 4) ?
              pkt(8'd12, PL'(32'h55 + c)) : '0;
      if (c >= 2) begin
        checks++;
        if (bus_o !== exp_q[c-2]) begin
          failures++;
          $display("FAIL bounce_seq%0d got=%h exp=%h",
                   c, bus_o, exp_q[c-2]);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_tx_full();
    logic [PS-1:0] pushed[DEP];
    idle();
    for (int i = 0; i < DEP; i++) begin
      din_valid = 1'b1;
      din_dest  = AW'($urandom_range(0, 255));
      din       = rnd_pl();
      bus_i     = pkt(8'd12, rnd_pl());
      pushed[i] = {1'b1, din_dest, din};
      checks++;
      if (din_ready !== 1'b1) begin
        failures++;
        $display("FAIL txf_ready%0d got=%b exp=1", i, din_ready);
      end
      tick();
    end
    din  = rnd_pl();
    checks++;
    if (din_ready !== 1'b0) begin
      failures++;
      $display("FAIL txf_full got=%b exp=0", din_ready);
    end
    tick();
    bus_i = '0;
    checks++;
    if (din_ready !== 1'b0) begin
      failures++;
      $display("FAIL txf_full2 got=%b exp=0", din_ready);
    end
    tick();
    din_valid = 1'b0;
    checks++;
    if (din_ready !== 1'b1) begin
      failures++;
      $display("FAIL txf_free got=%b exp=1", din_ready);
    end
    for (int i = 0; i < DEP; i++) begin
      checks++;
      if (bus_o !== pushed[i]) begin
        failures++;
        $display("FAIL txf_drain%0d got=%h exp=%h",
                 i, bus_o, pushed[i]);
      end
      tick();
    end
    checks++;
    if (bus_o !== '0) begin
      failures++;
      $display("FAIL txf_empty got=%h exp=0", bus_o);
    end
    idle();
  endtask

  task automatic test_rx_overflow();
    logic [PL-1:0] p[DEP+3];
    idle();
    for (int i = 0; i < DEP + 3; i++) begin
      p[i]  = rnd_pl();
      bus_i = pkt(ME, p[i]);
      tick();
    end
    bus_i = '0;
    checks++;
    if (rx_overflow !== 1'b1 || rx_drop_cnt !== 16'd3) begin
      failures++;
      $display("FAIL rxo_drop got=%b/%0d exp=1/3",
               rx_overflow, rx_drop_cnt);
    end
    dout_ready = 1'b1;
    for (int i = 0; i < DEP; i++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== p[i]) begin
        failures++;
        $display("FAIL rxo_rd%0d got=%b/%h exp=1/%h",
                 i, dout_valid, dout, p[i]);
      end
      tick();
    end
    dout_ready = 1'b0;
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL rxo_empty got=%b exp=0", dout_valid);
    end
    for (int i = 0; i <= DEP; i++) begin
      p[i]  = rnd_pl();
      bus_i = pkt(ME, p[i]);
      dout_ready = (i == DEP);
      tick();
    end
    idle();
    checks++;
    if (rx_drop_cnt !== 16'd3 || rx_overflow !== 1'b1) begin
      failures++;
      $display("FAIL rxo_nodrop got=%b/%0d exp=1/3",
               rx_overflow, rx_drop_cnt);
    end
    dout_ready = 1'b1;
    for (int i = 1; i <= DEP; i++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== p[i]) begin
        failures++;
        $display("FAIL rxo_rd2_%0d got=%b/%h exp=1/%h",
                 i, dout_valid, dout, p[i]);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_midstream();
    idle();
    for (int i = 0; i < 4; i++) begin
      bus_i     = pkt(ME, rnd_pl());
      din_valid = 1'b1;
      din       = rnd_pl();
      din_dest  = 8'd33;
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      bus_i = pkt(8'd77, rnd_pl());
      din   = rnd_pl();
      tick();
    end
    checks++;
    if (dout_valid !== 1'b1 || bus_o === '0) begin
      failures++;
      $display("FAIL mrst_pre got=%b/%h exp=1/nonzero",
               dout_valid, bus_o);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus_o !== '0 || dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL mrst_out got=%h/%b exp=0/0", bus_o, dout_valid);
    end
    checks++;
    if (rx_drop_cnt !== 16'd0 || rx_overflow !== 1'b0) begin
      failures++;
      $display("FAIL mrst_cnt got=%b/%0d exp=0/0",
               rx_overflow, rx_drop_cnt);
    end
    checks++;
    if (din_ready !== 1'b0) begin
      failures++;
      $display("FAIL mrst_ready got=%b exp=0", din_ready);
    end
    idle();
    reset = 1'b1;
    tick();
    checks++;
    if (din_ready !== 1'b1 || bus_o !== '0 || dout_valid !== 1'b0)
    begin
      failures++;
      $display("FAIL mrst_rel got=%b/%h/%b exp=1/0/0",
               din_ready, bus_o, dout_valid);
    end
  endtask

  task automatic test_random();
    int r;
    logic [AW-1:0] d;
    idle();
    for (int c = 0; c < 800; c++) begin
      din_valid = 1'($urandom_range(0, 1));
      din_dest  = AW'($urandom_range(0, 255));
      din       = rnd_pl();
      r = $urandom_range(0, 5);
      d = AW'($urandom_range(0, 255));
      if (d == ME) d = 8'd6;
      if (r < 2)      bus_i = '0;
      else if (r < 4) bus_i = pkt(ME, rnd_pl());
      else            bus_i = pkt(d, rnd_pl());
      if (c < 400) dout_ready = ($urandom_range(0, 3) == 0);
      else         dout_ready = 1'($urandom_range(0, 1));
      checks++;
      if (bus_o !== m_bus) begin
        failures++;
        $display("FAIL rnd_bus%0d got=%h exp=%h", c, bus_o, m_bus);
      end
      checks++;
      if (din_ready !== (m_up && txq.size() < DEP)) begin
        failures++;
        $display("FAIL rnd_ready%0d got=%b exp=%0d",
                 c, din_ready, txq.size());
      end
      checks++;
      if (dout_valid !== (rxq.size() > 0)) begin
        failures++;
        $display("FAIL rnd_dv%0d got=%b exp=%0d",
                 c, dout_valid, rxq.size());
      end
      if (rxq.size() > 0) begin
        checks++;
        if (dout !== rxq[0]) begin
          failures++;
          $display("FAIL rnd_dout%0d got=%h exp=%h", c, dout, rxq[0]);
        end
      end
      checks++;
      if (rx_overflow !== m_ovf || rx_drop_cnt !== m_cnt) begin
        failures++;
        $display("FAIL rnd_drop%0d got=%b/%0d exp=%b/%0d",
                 c, rx_overflow, rx_drop_cnt, m_ovf, m_cnt);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_idle_injection();
    test_deliver();
    test_bounce_priority();
    test_tx_full();
    test_rx_overflow();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bft_leaf_interface.md
# bft_leaf_interface

Leaf-side endpoint of the BFT deflection network: the other end of the packet bus driven by the level-0 `t_switch`. It packetizes a local valid/ready payload stream into network packets and drives them upward. It also accepts every packet the switch delivers, without backpressure. Packets addressed to this leaf go to a local receive queue. Packets bounced back by the level-0 turnback rule are re-injected ahead of fresh traffic.

## Interface
- `num_leaves`, 256, leaf count; address width `AW = $clog2(num_leaves)`
- `payload_sz`, 43, payload bits
- `addr`, 0, this leaf's address (`AW` bits)
- `p_sz`, 52, packet width; must equal `1 + AW + payload_sz`
- `tx_depth`, 16, transmit FIFO entries (power of 2)
- `rx_depth`, 16, receive FIFO entries (power of 2)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-low; `reset==0` at a rising edge resets the block
- `din` in `payload_sz`: payload to send
- `din_dest` in `AW`: destination leaf
- `din_valid` in 1: `din`/`din_dest` valid
- `din_ready` out 1: transmit FIFO can accept
- `bus_o` out `p_sz`: packet to switch, registered; layout `{valid, dest, payload}`
- `bus_i` in `p_sz`: packet from switch, same layout
- `dout` out `payload_sz`: received payload (show-ahead)
- `dout_valid` out 1: `dout` valid
- `dout_ready` in 1: consumer pops
- `rx_overflow` out 1: sticky, set when a self-addressed packet is dropped
- `rx_drop_cnt` out 16: saturating count of dropped packets

## Operation
- Transmit:
  - Push `{1'b1, din_dest, din}` into the tx FIFO when `din_valid && din_ready`.
  - `din_ready = !tx_full`. It is a function of the registered full flag only; a same-cycle pop does not raise it.
- Receive decode of `bus_i`, combinational, every cycle:
  - `bus_i[p_sz-1]==0`: ignore.
  - valid and `dest==addr`: deliver, i.e. push the payload into the rx FIFO.
  - valid and `dest!=addr`: bounce.
- Output select, registered each edge, in priority order:
  1. Bounce present: `bus_o <= bus_i` unchanged; the tx FIFO is not popped.
  2. Else tx FIFO non-empty: `bus_o <=` tx head; pop.
  3. Else `bus_o <= 0`.
- No bounce holding buffer is needed. At most one bounce arrives per cycle, and the output slot is always free for it.
- Fresh traffic starves while bounces arrive back to back; this is accepted.
- Rx FIFO full with an incoming deliver:
  - If `dout_ready && dout_valid` in the same cycle: the write succeeds (simultaneous pop and push).
  - Otherwise: drop the packet, set `rx_overflow`, and increment `rx_drop_cnt`. The counter saturates at 0xFFFF.
- Self-addressed injections (`din_dest==addr`) are sent to the network like any other packet. There is no local loopback.
- Reset values:
  - `bus_o=0`, `dout_valid=0`, `din_ready=0` while reset is held.
  - `rx_overflow=0`, `rx_drop_cnt=0`.
  - Both FIFOs empty; pointers cleared.
  - `din_ready=1` in the first cycle after reset deasserts.
- Reset mid-operation: FIFO contents are discarded and in-flight packets are lost. `bus_o` is 0 from the edge at which reset is sampled low.

## Timing
- Fresh injection into an idle block: accepted in cycle t, visible on `bus_o` in cycle t+2.
- Bounce: on `bus_i` in cycle t, on `bus_o` in cycle t+1. Latency 1; this matches the switch's one-cycle hop.
- Deliver: on `bus_i` in cycle t, `dout_valid` in cycle t+1 if the rx FIFO was empty.
- Throughput: one packet per cycle in each direction.
- `dout` and `dout_valid` are stable while `dout_ready` is low.
- Pointer width is `log2(depth)+1`, with the wrap bit distinguishing full from empty. Pointers wrap modulo 2·depth.

## Structure
- Shared header `bft_packet_params.vh`: field macros for the valid bit index (`p_sz-1`) and the dest slice (`p_sz-2 : payload_sz`). `t_switch` already uses this layout.
- Sub-module `sync_fifo` (parameters `width`, `depth`; ports push/pop/full/empty; show-ahead head), instantiated twice:
  - tx: `width = p_sz`
  - rx: `width = payload_sz`
- Top-level logic: decode, output mux register, drop counter.

## Test plan
- Idle injection: `addr=5`; push dest=9, payload=0x123 in cycle 0 → `bus_o={1,9,0x123}` in cycle 2, then `bus_o=0`.
- Deliver: `bus_i={1,5,0x7AA}` in cycle t → `dout=0x7AA`, `dout_valid=1` in cycle t+1; held until `dout_ready`.
- Bounce priority: tx FIFO holds 3 packets; `bus_i={1,12,0x55}` for 2 cycles → those packets on `bus_o` first, tx packets resume after with order preserved.
- Tx full: 16 pushes with no output → `din_ready=0`; first free slot → `din_ready=1` one cycle later; no packet lost or duplicated.
- Rx overflow: 16 delivers with `dout_ready=0`, then 3 more → `rx_overflow=1`, `rx_drop_cnt=3`, first 16 payloads read in order. Repeat with `dout_ready=1` on the 17th → no drop.
- Reset mid-stream: assert `reset=0` with both FIFOs non-empty → next cycle `bus_o=0`, `dout_valid=0`, `rx_drop_cnt=0`; `din_ready=1` the cycle after release.
